// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed restoring divider, Z = {remainder, quotient}
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  output logic [2*WIDTH-1:0]   Z,
  output logic                 busy,
  output logic                 done,
  output logic                 dbz
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_sx;
  logic             r_sy;
  logic             r_dz;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_ay;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_abs_x;
  logic [WIDTH-1:0] w_abs_y;
  logic [WIDTH:0]   w_shift_rem;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign w_abs_x = X[WIDTH-1] ? -X : X;
  assign w_abs_y = Y[WIDTH-1] ? -Y : Y;

  // r_quot starts as |X| and its MSBs feed the remainder while quotient bits fill from the LSB.
  // The shifted remainder needs one extra bit; after a subtract it always fits back in WIDTH.
  assign w_shift_rem = {r_rem, r_quot[WIDTH-1]};
  assign w_ge        = (w_shift_rem >= {1'b0, r_ay});
  assign w_diff      = w_shift_rem[WIDTH-1:0] - r_ay;

  assign w_q_fix = r_dz ? '1  : ((r_sx ^ r_sy) ? -r_quot : r_quot);
  assign w_r_fix = r_dz ? r_x : (r_sx ? -r_rem : r_rem);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sx    <= 1'b0;
      r_sy    <= 1'b0;
      r_dz    <= 1'b0;
      r_x     <= '0;
      r_ay    <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      Z       <= '0;
      dbz     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_sx   <= X[WIDTH-1];
        r_sy   <= Y[WIDTH-1];
        r_dz   <= (Y == '0);
        r_x    <= X;
        r_ay   <= w_abs_y;
        r_quot <= w_abs_x;
        r_rem  <= '0;
        r_cnt  <= '0;
      end else if (r_state == S_RUN) begin
        r_rem  <= w_ge ? w_diff : w_shift_rem[WIDTH-1:0];
        r_quot <= {r_quot[WIDTH-2:0], w_ge};
        r_cnt  <= r_cnt + 1'b1;
      end
      if (r_state == S_FIX) begin
        Z   <= {w_r_fix, w_q_fix};
        dbz <= r_dz;
      end
    end
  end

  assign busy = (r_state == S_RUN) || (r_state == S_FIX);
  assign done = (r_state == S_DONE);

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] X;
  logic [31:0] Y;
  logic [63:0] Z;
  logic        busy;
  logic        done;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .X     (X),
    .Y     (Y),
    .Z     (Z),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] z;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed truncating division from the language, plus the two special rules.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [63:0] z, output logic dz);
    int sx;
    int sy;
    int q;
    int r;
    sx = x;
    sy = y;
    dz = 1'b0;
    if (y == 32'd0) begin
      dz = 1'b1;
      q  = -1;
      r  = sx;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      q = sx;
      r = 0;
    end else begin
      q = sx / sy;
      r = sx % sy;
    end
    z = {r, q};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        output logic [63:0] z_o, output logic dbz_o, output int lat);
    int busy_bad;
    busy_bad = 0;
    @(negedge clk);
    X = x;
    Y = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    X = $urandom;
    Y = $urandom;
    lat = 1;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("busy_during_op", 64'(busy_bad), 64'd0);
    chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    z_o   = Z;
    dbz_o = dbz;
  endtask

  task automatic step_until_done(inout int n, input int limit);
    while (done !== 1'b1 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] z_got;
    logic [63:0] z_exp;
    logic        d_got;
    logic        d_exp;
    int          lat;
    int          n;
    int          pulses;

    vecs[0]  = '{32'd100,       32'd7,         {32'd2,         32'd14},         1'b0};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         {32'hFFFFFFFE,  32'hFFFFFFF2},   1'b0};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  {32'd2,         32'hFFFFFFF2},   1'b0};
    vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  {32'hFFFFFFFE,  32'd14},         1'b0};
    vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  {32'd0,         32'h80000000},   1'b0};
    vecs[5]  = '{32'h80000000,  32'd1,         {32'd0,         32'h80000000},   1'b0};
    vecs[6]  = '{32'd0,         32'd5,         {32'd0,         32'd0},          1'b0};
    vecs[7]  = '{32'd5,         32'd0,         {32'd5,         32'hFFFFFFFF},   1'b1};
    vecs[8]  = '{32'd9,         32'd3,         {32'd0,         32'd3},          1'b0};
    vecs[9]  = '{32'd7,         32'd100,       {32'd7,         32'd0},          1'b0};
    vecs[10] = '{32'hFFFFFFFF,  32'd2,         {32'hFFFFFFFF,  32'd0},          1'b0};
    vecs[11] = '{32'h7FFFFFFF,  32'h80000000,  {32'h7FFFFFFF,  32'd0},          1'b0};

    reset = 1'b1;
    start = 1'b1;
    X = 32'd100;
    Y = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_z",    Z,             64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_dbz",  {63'd0, dbz},  64'd0);
    start = 1'b0;
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].x, vecs[i].y, z_got, d_got, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("vec%0d_z", i), z_got, vecs[i].z);
      chk($sformatf("vec%0d_dbz", i), {63'd0, d_got}, {63'd0, vecs[i].dz});
    end

    @(posedge clk);
    #1;
    chk("done_single_cycle", {63'd0, done}, 64'd0);
    chk("idle_busy",         {63'd0, busy}, 64'd0);
    chk("idle_z_hold",       Z,             vecs[11].z);

    // Start ignored mid-run, then back-to-back start in the DONE cycle.
    @(negedge clk);
    X = 32'd8;
    Y = 32'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (n < 5) begin
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b1;
    X = 32'd50;
    Y = 32'd5;
    @(posedge clk);
    #1;
    n++;
    start = 1'b0;
    X = 32'd123;
    Y = 32'd0;
    step_until_done(n, 60);
    chk("proto_first_done_cycle", 64'(n), 64'd34);
    chk("proto_first_z", Z, {32'd0, 32'd4});
    X = 32'd50;
    Y = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #1;
    n++;
    start = 1'b0;
    chk("proto_b2b_busy", {63'd0, busy}, 64'd1);
    step_until_done(n, 100);
    chk("proto_second_done_cycle", 64'(n), 64'd68);
    chk("proto_second_z", Z, {32'd0, 32'd10});

    // Reset mid-operation.
    @(negedge clk);
    X = 32'd1000;
    Y = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 1;
    while (n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_z",    Z,             64'd0);
    chk("abort_dbz",  {63'd0, dbz},  64'd0);
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("abort_no_activity", 64'(pulses), 64'd0);
    run_op(32'd1000, 32'd3, z_got, d_got, lat);
    chk("fresh_latency", 64'(lat), 64'd34);
    chk("fresh_z", z_got, {32'd1, 32'd333});

    for (int i = 0; i < 60; i++) begin
      logic [31:0] rx;
      logic [31:0] ry;
      rx = $urandom;
      ry = $urandom;
      case ($urandom_range(0, 7))
        0: ry = 32'd0;
        1: ry = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
        2: rx = 32'h8000_0000;
        3: ry = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : -32'($urandom_range(1, 20));
        4: rx = 32'($urandom_range(0, 50));
        default: ;
      endcase
      model(rx, ry, z_exp, d_exp);
      run_op(rx, ry, z_got, d_got, lat);
      chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("rand%0d_z x=%h y=%h", i, rx, ry), z_got, z_exp);
      chk($sformatf("rand%0d_dbz", i), {63'd0, d_got}, {63'd0, d_exp});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
